// File: rtl/ifetch.sv
// ifetch: fetch FSM with one outstanding word read, PC step/jump control and a one-entry decode buffer.
// Latency: request handshake -> instr_valid after 2 cycles with zero-wait memory; at least 3 cycles per instruction.
// Backpressure: request held stable while mem_ready=0; buffer held and fetch paused while instr_ready=0. Option: IFETCH_MISALIGN_TRAP_EN.
package ifetch_pkg;
    typedef enum logic [1:0] {
        PC_HOLD = 2'd0,
        PC_STEP = 2'd1,
        PC_JUMP = 2'd2
    } pc_ctl_t;
endpackage

module ifetch
    import ifetch_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] addr_in,
    input  logic        misaligned,
    output pc_ctl_t     pc_ctl,
    output logic        mem_req_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_out,
    output logic [31:0] instr_pc,
    input  logic        redirect,
    output logic        fault
);

`ifdef IFETCH_MISALIGN_TRAP_EN
    typedef enum logic [2:0] {REQ, WAIT, BUF, DRAIN, FAULT} state_t;
`else
    typedef enum logic [1:0] {REQ, WAIT, BUF, DRAIN} state_t;
`endif

    state_t      state;
    state_t      state_nxt;
    logic [31:0] fetch_addr;
    logic [31:0] req_addr;
    logic        hs;
    logic        capture;

`ifdef IFETCH_MISALIGN_TRAP_EN
    assign fetch_addr = addr_in;
`else
    // Without the trap the low PC bits are ignored and the word is fetched aligned.
    logic unused_bits;
    assign unused_bits = ^{addr_in[1:0], misaligned};
    assign fetch_addr  = {addr_in[31:2], 2'b00};
`endif

    assign mem_addr = fetch_addr;
    assign hs       = mem_req_valid & mem_ready;
    assign capture  = (state == WAIT) & mem_rvalid & ~redirect;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= REQ;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            REQ: begin
                if (redirect) begin
                    // A request accepted alongside a redirect still owes us a response.
                    state_nxt = hs ? DRAIN : REQ;
                end
`ifdef IFETCH_MISALIGN_TRAP_EN
                else if (misaligned) begin
                    state_nxt = FAULT;
                end
`endif
                else if (hs) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    state_nxt = redirect ? REQ : BUF;
                end else if (redirect) begin
                    state_nxt = DRAIN;
                end
            end
            BUF: begin
                if (redirect || instr_ready) begin
                    state_nxt = REQ;
                end
            end
            DRAIN: begin
                if (mem_rvalid) begin
                    state_nxt = REQ;
                end
            end
`ifdef IFETCH_MISALIGN_TRAP_EN
            FAULT: begin
                if (redirect) begin
                    state_nxt = REQ;
                end
            end
`endif
            default: state_nxt = REQ;
        endcase
    end

    always_comb begin
        mem_req_valid = 1'b0;
        pc_ctl        = PC_HOLD;
        instr_valid   = 1'b0;
        fault         = 1'b0;
        if (state == REQ) begin
`ifdef IFETCH_MISALIGN_TRAP_EN
            mem_req_valid = ~misaligned;
`else
            mem_req_valid = 1'b1;
`endif
        end
        if (redirect) begin
            pc_ctl = PC_JUMP;
        end else if ((state == WAIT) && mem_rvalid) begin
            pc_ctl = PC_STEP;
        end
        instr_valid = (state == BUF);
`ifdef IFETCH_MISALIGN_TRAP_EN
        fault = (state == FAULT);
`endif
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            req_addr  <= 32'h0;
            instr_out <= 32'h0;
            instr_pc  <= 32'h0;
        end else begin
            if (hs) begin
                req_addr <= fetch_addr;
            end
            if (capture) begin
                instr_out <= mem_rdata;
                instr_pc  <= req_addr;
            end
        end
    end

endmodule
